// File: rtl/frame_serializer_pkg.sv
// Shared channel definitions for the frame serializer: default sync pattern,
// FIFO sizing and FSM state encodings.
package frame_serializer_pkg;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hEB90;
    localparam int          SYNC_BITS         = 16;
    localparam int          FIFO_DEPTH        = 8;
    localparam int          PTR_W             = $clog2(FIFO_DEPTH);
    localparam int          COUNT_W           = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } state_t;

endpackage

// File: rtl/frame_serializer_if.sv
// Byte-stream handshake into the serializer: the source drives data/valid,
// the serializer answers with ready.
interface frame_serializer_if;

    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/frame_serializer_byte_fifo.sv
// 8-bit wide byte FIFO with occupancy count; pushes are ignored when full and
// pops are ignored when empty.
module byte_fifo
    import frame_serializer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic [COUNT_W-1:0] count,
    output logic               full
);

    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == COUNT_W'(FIFO_DEPTH));
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + COUNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - COUNT_ONE;
            end
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Serializes buffered payload bytes into fixed-length frames:
// sync word, payload MSB first, even parity bit, then idle gap zeros.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
    parameter int          PAYLOAD_BYTES = 4,
    parameter int          GAP_BITS      = 2
) (
    input  logic                clk,
    input  logic                reset,
    frame_serializer_if.slave   bus,
    output logic                data_o,
    output logic                frame_active,
    output logic [7:0]          frame_count
);

    localparam logic [6:0]         SYNC_LAST    = 7'(SYNC_BITS - 1);
    localparam logic [6:0]         PAYLOAD_LAST = 7'(8 * PAYLOAD_BYTES - 1);
    localparam logic [6:0]         GAP_LAST     = 7'(GAP_BITS - 1);
    localparam logic [COUNT_W-1:0] START_LEVEL  = COUNT_W'(PAYLOAD_BYTES);

    state_t             state;
    state_t             state_next;
    logic [6:0]         bit_cnt;
    logic [6:0]         bit_cnt_next;
    logic [7:0]         shift;
    logic [7:0]         shift_next;
    logic               parity;
    logic               parity_next;
    logic               data_next;
    logic               active_next;
    logic [7:0]         frame_count_next;
    logic               fifo_pop;
    logic [7:0]         fifo_dout;
    logic [COUNT_W-1:0] fifo_count;
    logic               fifo_full;
    logic               can_start;

    byte_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.valid_in),
        .pop   (fifo_pop),
        .din   (bus.data_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full)
    );

    assign bus.ready_out = !fifo_full;
    assign can_start     = (fifo_count >= START_LEVEL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            parity       <= 1'b0;
            data_o       <= 1'b0;
            frame_active <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            shift        <= shift_next;
            parity       <= parity_next;
            data_o       <= data_next;
            frame_active <= active_next;
            frame_count  <= frame_count_next;
        end
    end

    // State names the bit currently on data_o; each branch computes the bit
    // that follows it so the output is registered with no extra latency.
    always_comb begin
        state_next       = state;
        bit_cnt_next     = bit_cnt;
        shift_next       = shift;
        parity_next      = parity;
        data_next        = 1'b0;
        active_next      = 1'b0;
        frame_count_next = frame_count;
        fifo_pop         = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (can_start) begin
                    state_next   = ST_SYNC;
                    bit_cnt_next = '0;
                    data_next    = SYNC_WORD[15];
                    active_next  = 1'b1;
                end
            end
            ST_SYNC: begin
                active_next = 1'b1;
                if (bit_cnt != SYNC_LAST) begin
                    bit_cnt_next = bit_cnt + 7'd1;
                    data_next    = SYNC_WORD[4'd14 - bit_cnt[3:0]];
                end else begin
                    state_next   = ST_PAYLOAD;
                    bit_cnt_next = '0;
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_dout;
                    data_next    = fifo_dout[7];
                    parity_next  = fifo_dout[7];
                end
            end
            ST_PAYLOAD: begin
                active_next = 1'b1;
                if (bit_cnt != PAYLOAD_LAST) begin
                    bit_cnt_next = bit_cnt + 7'd1;
                    // A fresh byte leaves the FIFO exactly when its MSB is due.
                    if (bit_cnt[2:0] == 3'd7) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                    end else begin
                        shift_next = {shift[6:0], 1'b0};
                    end
                    data_next   = shift_next[7];
                    parity_next = parity ^ shift_next[7];
                end else begin
                    state_next  = ST_PARITY;
                    data_next   = parity;
                    active_next = 1'b1;
                end
            end
            ST_PARITY: begin
                state_next       = ST_GAP;
                bit_cnt_next     = '0;
                frame_count_next = frame_count + 8'd1;
            end
            ST_GAP: begin
                if (bit_cnt != GAP_LAST) begin
                    bit_cnt_next = bit_cnt + 7'd1;
                end else if (can_start) begin
                    state_next   = ST_SYNC;
                    bit_cnt_next = '0;
                    data_next    = SYNC_WORD[15];
                    active_next  = 1'b1;
                end else begin
                    state_next   = ST_IDLE;
                    bit_cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer: directed scenarios plus random
// traffic, compared every cycle against a queue-based frame model.
module tb_frame_serializer;

    localparam int P          = 4;
    localparam int G          = 2;
    localparam int FRAME_BITS = 17 + 8 * P;
    localparam int LEN        = FRAME_BITS + G;

    logic       clk;
    logic       reset;
    logic       data_o;
    logic       frame_active;
    logic [7:0] frame_count;

    frame_serializer_if bus ();

    frame_serializer #(
        .SYNC_WORD     (16'hEB90),
        .PAYLOAD_BYTES (P),
        .GAP_BITS      (G)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .data_o       (data_o),
        .frame_active (frame_active),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0]          sync_word = 16'hEB90;
    logic [7:0]           q[$];
    logic [7:0]           frame_bytes[$];
    int                   pos = -1;
    int                   fc = 0;
    int                   frames_total = 0;
    logic                 drv_valid = 1'b0;
    logic [7:0]           drv_data = '0;
    logic [FRAME_BITS-1:0] capt = '0;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_data();
        logic p;
        if (pos < 0) return 1'b0;
        if (pos < 16) return sync_word[15 - pos];
        if (pos < 16 + 8 * P) return frame_bytes[(pos - 16) / 8][7 - ((pos - 16) % 8)];
        if (pos == 16 + 8 * P) begin
            p = 1'b0;
            foreach (frame_bytes[i]) p ^= ^frame_bytes[i];
            return p;
        end
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the pre-edge queue size.
    task automatic model_step();
        int  pre_size;
        logic accept;
        pre_size = q.size();
        accept   = drv_valid && (pre_size < 8);
        if (pos >= 0 && pos < LEN - 1) begin
            pos++;
        end else if (pre_size >= P) begin
            pos = 0;
            frame_bytes.delete();
        end else begin
            pos = -1;
        end
        if (pos >= 16 && pos < 16 + 8 * P && ((pos - 16) % 8) == 0)
            frame_bytes.push_back(q.pop_front());
        if (pos == FRAME_BITS) begin
            fc = (fc + 1) % 256;
            frames_total++;
        end
        if (accept) q.push_back(drv_data);
    endtask

    task automatic check_output();
        check8("data_o", {7'd0, data_o}, {7'd0, exp_data()});
        check8("frame_active", {7'd0, frame_active}, {7'd0, (pos >= 0 && pos < FRAME_BITS)});
        check8("ready_out", {7'd0, bus.ready_out}, {7'd0, (q.size() < 8)});
        check8("frame_count", frame_count, 8'(fc));
        if (pos >= 0 && pos < FRAME_BITS) capt[FRAME_BITS - 1 - pos] = data_o;
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d);
        @(negedge clk);
        drv_valid    = v;
        drv_data     = d;
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drv_valid    = 1'b0;
        bus.valid_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check8("rst_data_o", {7'd0, data_o}, 8'd0);
        check8("rst_frame_active", {7'd0, frame_active}, 8'd0);
        check8("rst_frame_count", frame_count, 8'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        frame_bytes.delete();
        pos = -1;
        fc  = 0;
        frames_total = 0;
        #1;
        check8("rst_ready_out", {7'd0, bus.ready_out}, 8'd1);
    endtask

    initial begin
        int fc_before;
        int budget;
        logic [7:0] b;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check8("init_ready_out", {7'd0, bus.ready_out}, 8'd1);
        check8("init_data_o", {7'd0, data_o}, 8'd0);
        idle(3);

        $display("[TB] single frame 01 02 03 04");
        for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 8'(i));
        idle(60);
        check8("single_frame_hi", 8'(capt[48:41]), 8'b11101011);
        check8("single_frame_sync_lo", capt[40:33], 8'b10010000);
        check8("single_frame_payload", capt[32:25], 8'h01);
        check8("single_frame_tail", {4'd0, capt[8:5]}, 8'h0);
        check8("single_frame_last", capt[8:1], 8'h04);
        check8("single_frame_parity", {7'd0, capt[0]}, 8'd1);
        check8("single_frame_count", frame_count, 8'd1);

        $display("[TB] partial data then fourth byte");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'($urandom));
        idle(80);
        apply_stimulus(1'b1, 8'($urandom));
        idle(60);

        $display("[TB] back-to-back frames");
        fc_before = fc;
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'($urandom));
        idle(120);
        check8("b2b_count", frame_count, 8'(fc_before + 2));

        $display("[TB] backpressure with incrementing bytes");
        b = 8'h10;
        for (int i = 0; i < 150; i++) begin
            apply_stimulus(1'b1, b);
            if (bus.ready_out || q.size() < 8) b = b + 8'd1;
        end
        idle(160);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++)
            apply_stimulus(($urandom_range(0, 2) == 0), 8'($urandom));
        idle(160);

        $display("[TB] reset mid-payload");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'($urandom));
        budget = 0;
        while (pos != 27 && budget < 200) begin
            apply_stimulus(1'b0, 8'h00);
            budget++;
        end
        check8("reach_payload", {7'd0, (pos == 27)}, 8'd1);
        do_reset();
        idle(5);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'hFF);
        idle(60);
        check8("ff_frame_payload", capt[32:25], 8'hFF);
        check8("ff_frame_parity", {7'd0, capt[0]}, 8'd0);
        check8("ff_frame_count", frame_count, 8'd1);

        $display("[TB] frame counter wrap");
        do_reset();
        budget = 0;
        while (frames_total < 256 && budget < 20000) begin
            apply_stimulus(1'b1, 8'($urandom));
            budget++;
        end
        check8("wrap_reached", {7'd0, (frames_total == 256)}, 8'd1);
        check8("wrap_count", frame_count, 8'd0);
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hEB90, frame sync pattern sent MSB first.
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 4, payload bytes per frame (legal 1..8).
REQ-003 SHALL have parameter GAP_BITS, default 2, idle zero bits after each frame (legal 1..15).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port data_in, input, 8, payload byte from source.
REQ-007 SHALL have port valid_in, input, 1, data_in valid.
REQ-008 SHALL have port ready_out, output, 1, block can accept a byte.
REQ-009 SHALL have port data_o, output, 1, registered serial bit stream, one bit per clk, driving transmitter data_i.
REQ-010 SHALL have port frame_active, output, 1, high while sync, payload or parity bits are on data_o.
REQ-011 SHALL have port frame_count, output, 8, completed-frame counter.

Function
REQ-012 SHALL buffer bytes in an 8-deep FIFO; byte accepted on a rising edge where valid_in && ready_out.
REQ-013 SHALL drive ready_out = FIFO not full; when full, ready_out low even if a pop occurs that cycle (no bypass).
REQ-014 SHALL implement FSM states IDLE, SYNC, PAYLOAD, PARITY, GAP.
REQ-015 IDLE: data_o=0, frame_active=0; transition to SYNC on an edge where FIFO count >= PAYLOAD_BYTES.
REQ-016 First sync bit SHALL appear on data_o in the cycle after that edge (byte accepted at edge k with count reaching PAYLOAD_BYTES -> SYNC[15] on data_o after edge k+1).
REQ-017 SYNC: 16 cycles, SYNC_WORD MSB first.
REQ-018 PAYLOAD: PAYLOAD_BYTES x 8 cycles; each byte popped from FIFO as its first bit is loaded; bits MSB first.
REQ-019 PARITY: 1 cycle, even parity over all payload bits (XOR of all payload bits).
REQ-020 GAP: GAP_BITS cycles of data_o=0, frame_active=0; frame_count increments by 1 (mod 256, wraps 255->0) on entry to GAP.
REQ-021 At GAP exit SHALL go to SYNC if FIFO count >= PAYLOAD_BYTES, else IDLE; frames never start with fewer bytes.
REQ-022 Frame length SHALL be 16 + 8*PAYLOAD_BYTES + 1 + GAP_BITS cycles (default 51), constant.
REQ-023 Pushes during a frame SHALL be accepted normally; simultaneous push and pop SHALL leave count unchanged.

Reset
REQ-024 Reset SHALL asynchronously force: FSM=IDLE, FIFO empty, data_o=0, frame_active=0, frame_count=0, ready_out=1 after release.
REQ-025 Reset mid-frame SHALL discard the partial frame and all buffered bytes; no resumption after release.

Structure
REQ-026 SYNC_WORD default, FIFO depth (8), and FSM state encodings SHALL live in the shared channel definitions include used by encoder/modulator.
REQ-027 FIFO SHALL be a separate sub-module byte_fifo (8-bit, depth 8, count output); FSM, shift register and parity in frame_serializer.

Verification
REQ-028 Reset values: assert reset mid-sim -> data_o=0, frame_active=0, frame_count=0 immediately; ready_out=1 after release.
REQ-029 Single frame: push 8'h01,02,03,04 -> data_o = 1110101110010000, 00000001, 00000010, 00000011, 00000100, parity 1, then 00; frame_count=1; FSM back in IDLE.
REQ-030 Back-to-back: push 8 bytes before first frame ends -> second SYNC[15] immediately follows 2 gap zeros; frame_count=2; no byte lost/duplicated.
REQ-031 Backpressure: hold valid_in high with incrementing bytes during a frame -> ready_out low exactly when count=8; output byte order equals accepted order.
REQ-032 Partial data: push 3 bytes -> data_o stays 0, frame_active stays 0 indefinitely; 4th byte starts frame per REQ-016 timing.
REQ-033 Reset mid-payload then push 4 bytes 8'hFF -> clean new frame with parity 0; wrap: 256 frames -> frame_count=0.
